// File: rtl/popcount_unary_gen_if.sv
// popcount_unary_gen_if
// Groups the count-in and bit-out handshakes of popcount_unary_gen.
//   cnt_i / cnt_valid_i / cnt_ready_o : count to expand (valid/ready)
//   bit_o / bit_valid_o / bit_ready_i : serial unary stream (valid/ready)
//   bit_last_o                        : current bit is position N_BITS-1
//   ovf_o                             : one-cycle pulse, accepted count > N_BITS
//   busy_o                            : stream in progress
//   thermo_o                          : parallel thermometer word
//                                       (only with POPGEN_THERMO_OUT_EN)
// Modports: slave = the generator, master = the driving environment.
interface popcount_unary_gen_if #(
  parameter int N_BITS = 4,
  parameter int CNT_W  = 3
);
  logic [CNT_W-1:0]  cnt_i;
  logic              cnt_valid_i;
  logic              cnt_ready_o;
  logic              bit_o;
  logic              bit_valid_o;
  logic              bit_ready_i;
  logic              bit_last_o;
  logic              ovf_o;
  logic              busy_o;
`ifdef POPGEN_THERMO_OUT_EN
  logic [N_BITS-1:0] thermo_o;
`endif

  modport slave (
    input  cnt_i, cnt_valid_i, bit_ready_i,
    output cnt_ready_o, bit_o, bit_valid_o, bit_last_o, ovf_o, busy_o
`ifdef POPGEN_THERMO_OUT_EN
    , output thermo_o
`endif
  );

  modport master (
    output cnt_i, cnt_valid_i, bit_ready_i,
    input  cnt_ready_o, bit_o, bit_valid_o, bit_last_o, ovf_o, busy_o
`ifdef POPGEN_THERMO_OUT_EN
    , input thermo_o
`endif
  );
endinterface

// File: rtl/popcount_unary_gen.sv
// popcount_unary_gen
// Expands a population count back into an N_BITS-long unary stream:
// ones first, then zeros, position 0 emitted first, one bit per handshake.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : popcount_unary_gen_if.slave (count in, bit stream out, status)
// Optional macro POPGEN_THERMO_OUT_EN adds a registered parallel thermometer
// word (bus.thermo_o) loaded on every count acceptance.
module popcount_unary_gen #(
  parameter int N_BITS = 4,
  parameter int CNT_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  popcount_unary_gen_if.slave  bus
);

  localparam int POS_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [CNT_W-1:0] NB_CNT   = CNT_W'(N_BITS);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(N_BITS - 1);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [POS_W-1:0] r_pos;
  logic [POS_W-1:0] w_pos_next;
  logic [CNT_W-1:0] r_cnt_q;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_ovf;
  logic             w_ovf_next;

  logic             w_emit;
  logic             w_accept;
  logic             w_last;
  logic [CNT_W-1:0] w_cnt_clamp;

  assign w_emit      = (r_state == EMIT);
  assign w_accept    = !w_emit && bus.cnt_valid_i;
  assign w_last      = (r_pos == LAST_POS);
  assign w_cnt_clamp = (bus.cnt_i > NB_CNT) ? NB_CNT : bus.cnt_i;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pos   <= '0;
      r_cnt_q <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pos   <= w_pos_next;
      r_cnt_q <= w_cnt_next;
      r_ovf   <= w_ovf_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_pos_next   = r_pos;
    w_cnt_next   = r_cnt_q;
    w_ovf_next   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.cnt_valid_i) begin
          w_state_next = EMIT;
          w_pos_next   = '0;
          w_cnt_next   = w_cnt_clamp;
          w_ovf_next   = (bus.cnt_i > NB_CNT);
        end
      end
      EMIT: begin
        if (bus.bit_ready_i) begin
          if (w_last) begin
            // No same-cycle re-accept: IDLE is visible for a cycle first.
            w_state_next = IDLE;
            w_pos_next   = '0;
          end else begin
            w_pos_next = r_pos + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_pos_next   = '0;
      end
    endcase
  end

  // Outputs are pure decodes of registers; bit/last are gated so IDLE
  // presents the reset values.
  assign bus.cnt_ready_o = !w_emit;
  assign bus.bit_valid_o = w_emit;
  assign bus.busy_o      = w_emit;
  assign bus.bit_o       = w_emit && (CNT_W'(r_pos) < r_cnt_q);
  assign bus.bit_last_o  = w_emit && w_last;
  assign bus.ovf_o       = r_ovf;

`ifdef POPGEN_THERMO_OUT_EN
  logic [N_BITS-1:0] r_thermo;
  logic [N_BITS-1:0] w_thermo_next;

  // Bit gi is set when it lies below the clamped count (LSB = first bit).
  for (genvar gi = 0; gi < N_BITS; gi++) begin : g_thermo
    assign w_thermo_next[gi] = (CNT_W'(gi) < w_cnt_clamp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_thermo <= '0;
    end else if (w_accept) begin
      r_thermo <= w_thermo_next;
    end
  end

  assign bus.thermo_o = r_thermo;
`endif

endmodule

// File: doc/popcount_unary_gen.md
Name: popcount_unary_gen

Overview:
- Inverse of the popcount blocks: takes a population count and regenerates a unary (thermometer-ordered) bit stream of N_BITS bits containing exactly that many ones.
- Used as stimulus/expansion stage in the popcount datapath: drives serial input lanes and re-expands counts for exact-vs-approximate comparison.
- Count enters via valid/ready; bits leave serially, one per handshake, with valid/ready and a last marker.

Parameters:
- N_BITS, 4, stream length in bits (number of inputs of the matching popcount, >=2).
- CNT_W, 3, count width; must equal clog2(N_BITS+1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- cnt_i  input  CNT_W  count to expand.
- cnt_valid_i  input  1  cnt_i valid.
- cnt_ready_o  output  1  block can accept a count.
- bit_o  output  1  current stream bit.
- bit_valid_o  output  1  bit_o valid.
- bit_ready_i  input  1  downstream accepts bit_o.
- bit_last_o  output  1  current bit is position N_BITS-1.
- ovf_o  output  1  one-cycle pulse: accepted count exceeded N_BITS.
- busy_o  output  1  stream in progress (state EMIT).

Behaviour:
- One clock domain (clk). rst is synchronous and active-high, sampled on the rising edge; it overrides all other inputs.
- Reset values: cnt_ready_o=1, bit_o=0, bit_valid_o=0, bit_last_o=0, ovf_o=0, busy_o=0, state=IDLE, pos=0, cnt_q=0.
- FSM states:
  - IDLE: cnt_ready_o=1, bit_valid_o=0.
  - EMIT: cnt_ready_o=0, bit_valid_o=1.
- IDLE -> EMIT on cnt_valid_i & cnt_ready_o at a rising edge. On that edge:
  - cnt_q <= min(cnt_i, N_BITS) (clamp).
  - pos <= 0.
  - ovf_o <= (cnt_i > N_BITS) for exactly one cycle; otherwise ovf_o=0.
- In EMIT, all outputs are combinational from registers:
  - bit_o = (pos < cnt_q).
  - bit_last_o = (pos == N_BITS-1).
  - busy_o = 1.
- Bit handshake is bit_valid_o & bit_ready_i.
  - On a handshake with pos < N_BITS-1: pos <= pos+1.
  - On a handshake with bit_last_o: state <= IDLE and pos <= 0.
- Stalls: while bit_ready_i=0, bit_o, bit_last_o and pos stay stable. The valid/ready rule holds: bit_valid_o never drops without a handshake.
- Stream order: ones first, then zeros. Position 0 is emitted first.
- Latency: first bit is valid in the cycle after count acceptance.
- Throughput: with bit_ready_i held high, one count per N_BITS+1 cycles. There is no same-cycle accept on the last-bit edge; cnt_ready_o rises the cycle after the last handshake.
- Boundary cases:
  - cnt=0: N_BITS zeros.
  - cnt=N_BITS: N_BITS ones.
  - cnt>N_BITS: clamped to N_BITS, with an ovf_o pulse.
- cnt_valid_i is ignored in EMIT; the upstream holds it, no data is lost.
- Reset mid-stream aborts immediately: next cycle is IDLE with reset values, and the partial stream is discarded.
- pos width is clog2(N_BITS). pos never wraps beyond N_BITS-1.

Optional Feature:
- Macro: POPGEN_THERMO_OUT_EN.
- Defined:
  - Adds output thermo_o [N_BITS-1:0], a registered parallel thermometer word.
  - On count acceptance, thermo_o <= bits [cnt_q-1:0] set, rest 0 (LSB = first serial bit). It holds until the next acceptance; reset value 0.
  - Serial behaviour is unchanged.
- Undefined: port absent, no extra registers. Serial behaviour is identical.

Test Plan:
- Reset, then cnt_i=3 with valid, bit_ready_i=1 -> cnt_ready_o drops next cycle; bits 1,1,1,0 on 4 consecutive cycles; bit_last_o only on the 4th; cnt_ready_o=1 the following cycle; ovf_o=0 throughout.
- cnt_i=0 and then cnt_i=4 back-to-back with valid held -> streams 0,0,0,0 then 1,1,1,1. The second count is accepted only after cnt_ready_o returns; 10 cycles total from the first accept to the second stream's end.
- cnt_i=7 (N_BITS=4) -> ovf_o=1 for exactly one cycle after accept; stream 1,1,1,1.
- cnt_i=2, bit_ready_i toggled 1,0,0,1,0,1,1 -> bit_o/bit_last_o stable during stalls; accepted bits 1,1,0,0; bit_valid_o stays high until the final handshake.
- cnt_i=3, assert rst after 2 accepted bits -> next cycle: bit_valid_o=0, cnt_ready_o=1, busy_o=0. A new cnt_i=1 then yields 1,0,0,0.
- With POPGEN_THERMO_OUT_EN, cnt_i=2 -> thermo_o=4'b0011 the cycle after accept, held through the stream. After reset thermo_o=0.
